// File: rtl/acc_tile_streamer_if.sv
// Tile-in / beat-out bus of the ACC-tile streamer.
// The slave modport is the streamer. The master modport is its environment, which
// offers whole tiles and consumes the beats.
interface acc_tile_streamer_if #(
    parameter int MAT_SIZE  = 16,
    parameter int ACC_W     = 32,
    parameter int LANES_NUM = 16
);
    localparam int ELEMS = MAT_SIZE * MAT_SIZE;

    logic                         tile_s_valid_i;
    logic                         tile_s_ready_o;
    logic [ELEMS*ACC_W-1:0]       tile_s_data_i;
    logic                         acc_m_valid_o;
    logic                         acc_m_ready_i;
    logic                         acc_m_tfirst_o;
    logic                         acc_m_tlast_o;
    logic [LANES_NUM*ACC_W-1:0]   acc_m_data_o;

    modport slave (
        input  tile_s_valid_i,
        input  tile_s_data_i,
        input  acc_m_ready_i,
        output tile_s_ready_o,
        output acc_m_valid_o,
        output acc_m_tfirst_o,
        output acc_m_tlast_o,
        output acc_m_data_o
    );

    modport master (
        output tile_s_valid_i,
        output tile_s_data_i,
        output acc_m_ready_i,
        input  tile_s_ready_o,
        input  acc_m_valid_o,
        input  acc_m_tfirst_o,
        input  acc_m_tlast_o,
        input  acc_m_data_o
    );
endinterface

// File: rtl/acc_tile_streamer.sv
// ACC-tile streamer: buffers whole accumulator tiles in a small ring of slots and
// emits each one as BEATS valid/ready beats of LANES_NUM words, tfirst on beat 0.

// Simulation checks on the buffer occupancy and beat counter.
module acc_tile_streamer_chk #(
    parameter int DEPTH  = 2,
    parameter int BEATS  = 4,
    parameter int CNT_W  = 2,
    parameter int BIDX_W = 3
) (
    input logic              clk,
    input logic              rst,
    input logic              push,
    input logic              pop,
    input logic [CNT_W-1:0]  count,
    input logic [BIDX_W-1:0] beat_idx
);
    a_count_range: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
    a_beat_range:  assert property (@(posedge clk) disable iff (rst) beat_idx < BIDX_W'(BEATS));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && count == CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && count == {CNT_W{1'b0}}));
endmodule

module acc_tile_streamer #(
    parameter int MAT_SIZE       = 16,
    parameter int ACC_W          = 32,
    parameter int LANES_NUM      = 16,
    parameter int TILE_BUF_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    acc_tile_streamer_if.slave                bus,
    input  logic                              flush_i,
    output logic                              busy_o,
    output logic [$clog2(TILE_BUF_DEPTH):0]   tiles_pending_o
);
    localparam int ELEMS  = MAT_SIZE * MAT_SIZE;
    localparam int BEATS  = (ELEMS + LANES_NUM - 1) / LANES_NUM;
    localparam int BEAT_W = LANES_NUM * ACC_W;
    localparam int TILE_W = ELEMS * ACC_W;
    localparam int PAD_W  = BEATS * BEAT_W;
    localparam int CNT_W  = $clog2(TILE_BUF_DEPTH) + 1;
    localparam int PTR_W  = (TILE_BUF_DEPTH > 1) ? $clog2(TILE_BUF_DEPTH) : 1;
    localparam int BIDX_W = $clog2(BEATS) + 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state_r, state_next_s;
    logic [CNT_W-1:0]    count_r, count_next_s;
    logic [PTR_W-1:0]    wr_ptr_r, wr_ptr_next_s;
    logic [PTR_W-1:0]    rd_ptr_r, rd_ptr_next_s;
    logic [BIDX_W-1:0]   beat_idx_r, beat_idx_next_s;
    logic                ready_s;
    logic                push_s;
    logic                beat_hs_s;
    logic                last_beat_s;
    logic                pop_s;
    logic [PAD_W-1:0]    tile_pad_s;
    logic [BEAT_W-1:0]   beat_data_s;

    // Tile storage; contents are deliberately not reset.
    logic [TILE_W-1:0]   buf_r [TILE_BUF_DEPTH];

    // Ring-pointer increment with wrap at the last slot.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(TILE_BUF_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Input-side ready: only registered occupancy, reset and flush feed it.
    always_comb begin
        if (rst || flush_i) begin
            ready_s = 1'b0;
        end else begin
            ready_s = (count_r < CNT_W'(TILE_BUF_DEPTH));
        end
    end

    assign push_s      = bus.tile_s_valid_i & ready_s;
    assign beat_hs_s   = (state_r == STREAM) & bus.acc_m_ready_i;
    assign last_beat_s = (beat_idx_r == BIDX_W'(BEATS - 1));
    assign pop_s       = beat_hs_s & last_beat_s;

    // Next occupancy, pointers and beat index; flush discards any push or pop.
    always_comb begin
        count_next_s    = count_r;
        wr_ptr_next_s   = wr_ptr_r;
        rd_ptr_next_s   = rd_ptr_r;
        beat_idx_next_s = beat_idx_r;
        if (flush_i) begin
            count_next_s    = {CNT_W{1'b0}};
            wr_ptr_next_s   = {PTR_W{1'b0}};
            rd_ptr_next_s   = {PTR_W{1'b0}};
            beat_idx_next_s = {BIDX_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_next_s = ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (beat_hs_s && last_beat_s) begin
                beat_idx_next_s = {BIDX_W{1'b0}};
                rd_ptr_next_s   = ptr_inc(rd_ptr_r);
            end else if (beat_hs_s) begin
                beat_idx_next_s = beat_idx_r + BIDX_W'(1);
            end else begin
                beat_idx_next_s = beat_idx_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CNT_W'(1);
                2'b01:   count_next_s = count_r - CNT_W'(1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // FSM next state: streaming whenever at least one tile will be buffered.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!flush_i && push_s) begin
                    state_next_s = STREAM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            STREAM: begin
                if (flush_i || (count_next_s == {CNT_W{1'b0}})) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STREAM;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, occupancy, pointer and beat-index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            count_r    <= {CNT_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            beat_idx_r <= {BIDX_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            count_r    <= count_next_s;
            wr_ptr_r   <= wr_ptr_next_s;
            rd_ptr_r   <= rd_ptr_next_s;
            beat_idx_r <= beat_idx_next_s;
        end
    end

    // Latch an accepted tile into the write slot.
    always_ff @(posedge clk) begin
        if (push_s) begin
            buf_r[wr_ptr_r] <= bus.tile_s_data_i;
        end
    end

    // Head tile widened to whole beats; lanes past the last element read as zero.
    always_comb begin
        tile_pad_s                = {PAD_W{1'b0}};
        tile_pad_s[TILE_W-1:0]    = buf_r[rd_ptr_r];
    end

    // Current beat slice of the head tile.
    always_comb begin
        beat_data_s = tile_pad_s[BEAT_W*int'(beat_idx_r) +: BEAT_W];
    end

    // FSM outputs; everything is zero outside STREAM so reset shows all-zero outputs.
    always_comb begin
        bus.acc_m_valid_o  = 1'b0;
        bus.acc_m_tfirst_o = 1'b0;
        bus.acc_m_tlast_o  = 1'b0;
        bus.acc_m_data_o   = {BEAT_W{1'b0}};
        busy_o             = 1'b0;
        case (state_r)
            IDLE: begin
                bus.acc_m_valid_o  = 1'b0;
                busy_o             = 1'b0;
            end
            STREAM: begin
                bus.acc_m_valid_o  = 1'b1;
                bus.acc_m_tfirst_o = (beat_idx_r == {BIDX_W{1'b0}});
                bus.acc_m_tlast_o  = last_beat_s;
                bus.acc_m_data_o   = beat_data_s;
                busy_o             = 1'b1;
            end
            default: begin
                bus.acc_m_valid_o  = 1'b0;
                busy_o             = 1'b0;
            end
        endcase
    end

    assign bus.tile_s_ready_o = ready_s;
    assign tiles_pending_o    = count_r;

    acc_tile_streamer_chk #(
        .DEPTH  (TILE_BUF_DEPTH),
        .BEATS  (BEATS),
        .CNT_W  (CNT_W),
        .BIDX_W (BIDX_W)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .pop      (pop_s),
        .count    (count_r),
        .beat_idx (beat_idx_r)
    );
endmodule

// File: tb/tb_acc_tile_streamer.sv
// Bench for acc_tile_streamer: a queue-of-tiles reference model for the 4x4/4-lane
// instance, plus a 3x3/4-lane instance for the padded last beat.
module tb_acc_tile_streamer;
    localparam int AW     = 32;
    localparam int LN     = 4;
    localparam int DEPTH  = 2;
    localparam int ELEMS  = 16;
    localparam int BEATS  = 4;
    localparam int TILE_W = ELEMS * AW;
    localparam int BEAT_W = LN * AW;
    localparam int ELEMS3 = 9;
    localparam int BEATS3 = 3;
    localparam int VEC_W  = 5 + 2 + BEAT_W;

    typedef logic [TILE_W-1:0] tile_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush4, flush3;
    logic       busy4, busy3;
    logic [1:0] pend4, pend3;

    acc_tile_streamer_if #(.MAT_SIZE(4), .ACC_W(AW), .LANES_NUM(LN)) bus4 ();
    acc_tile_streamer_if #(.MAT_SIZE(3), .ACC_W(AW), .LANES_NUM(LN)) bus3 ();

    acc_tile_streamer #(.MAT_SIZE(4), .ACC_W(AW), .LANES_NUM(LN), .TILE_BUF_DEPTH(DEPTH)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .flush_i(flush4), .busy_o(busy4), .tiles_pending_o(pend4));
    acc_tile_streamer #(.MAT_SIZE(3), .ACC_W(AW), .LANES_NUM(LN), .TILE_BUF_DEPTH(DEPTH)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .flush_i(flush3), .busy_o(busy3), .tiles_pending_o(pend3));

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    tile_t pend_q[$];
    int    cur_beat = 0;

    function automatic tile_t ramp_tile();
        tile_t t;
        for (int e = 0; e < ELEMS; e++) t[e*AW +: AW] = 32'h100 + 32'(e);
        return t;
    endfunction

    function automatic tile_t rand_tile();
        tile_t t;
        for (int e = 0; e < ELEMS; e++) t[e*AW +: AW] = $urandom();
        return t;
    endfunction

    // Expected outputs of the 4x4 instance from the tile queue and the head's beat number.
    function automatic logic [VEC_W-1:0] exp_vec();
        logic [BEAT_W-1:0] d;
        logic v, rdy;
        logic [1:0] p;
        d   = '0;
        v   = !rst && (pend_q.size() > 0);
        rdy = !rst && !flush4 && (pend_q.size() < DEPTH);
        p   = rst ? 2'd0 : 2'(pend_q.size());
        if (v) begin
            for (int l = 0; l < LN; l++) begin
                if (cur_beat*LN + l < ELEMS) d[l*AW +: AW] = pend_q[0][(cur_beat*LN + l)*AW +: AW];
            end
        end
        return {v, v && (cur_beat == 0), v && (cur_beat == BEATS-1), rdy, v, p, d};
    endfunction

    function automatic logic [VEC_W-1:0] got_vec();
        return {bus4.acc_m_valid_o, bus4.acc_m_tfirst_o, bus4.acc_m_tlast_o,
                bus4.tile_s_ready_o, busy4, pend4, bus4.acc_m_data_o};
    endfunction

    // Advance one clock and apply the same clock edge to the reference model.
    task automatic tick();
        bit acc, hs;
        acc = bus4.tile_s_valid_i && !rst && !flush4 && (pend_q.size() < DEPTH);
        hs  = !rst && !flush4 && (pend_q.size() > 0) && bus4.acc_m_ready_i;
        @(posedge clk);
        if (rst || flush4) begin
            pend_q.delete();
            cur_beat = 0;
        end else begin
            if (hs) begin
                if (cur_beat == BEATS-1) begin
                    void'(pend_q.pop_front());
                    cur_beat = 0;
                end else begin
                    cur_beat++;
                end
            end
            if (acc) pend_q.push_back(bus4.tile_s_data_i);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive4(input logic v, input tile_t d, input logic r, input logic f);
        bus4.tile_s_valid_i = v;
        bus4.tile_s_data_i  = d;
        bus4.acc_m_ready_i  = r;
        flush4              = f;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive4(1'b1, ramp_tile(), 1'b1, 1'b0);
        bus3.tile_s_valid_i = 1'b1;
        bus3.tile_s_data_i  = '0;
        bus3.acc_m_ready_i  = 1'b1;
        flush3              = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL reset4 cyc %0d: got %h required %h", cyc, got_vec(), exp_vec());
            end
            n_vec++;
            if ({bus3.tile_s_ready_o, bus3.acc_m_valid_o, busy3, pend3} !== 5'b0) begin
                n_err++;
                $display("FAIL reset3 cyc %0d: got %b required 00000", cyc,
                         {bus3.tile_s_ready_o, bus3.acc_m_valid_o, busy3, pend3});
            end
            tick();
        end
        rst = 1'b0;
        bus3.tile_s_valid_i = 1'b0;
        drive4(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_vec++;
        if ({bus4.tile_s_ready_o, busy4, pend4} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_release got %b required 1000", {bus4.tile_s_ready_o, busy4, pend4});
        end
        tick();
    endtask

    task automatic test_single();
        logic [BEAT_W-1:0] b0, b3;
        b0 = {32'h103, 32'h102, 32'h101, 32'h100};
        b3 = {32'h10F, 32'h10E, 32'h10D, 32'h10C};
        drive4(1'b1, ramp_tile(), 1'b1, 1'b0);
        #1;
        tick();
        drive4(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL single cyc %0d: got %h required %h", cyc, got_vec(), exp_vec());
            end
            if (i == 0) begin
                n_vec++;
                if ({bus4.acc_m_valid_o, bus4.acc_m_tfirst_o, bus4.acc_m_data_o} !== {2'b11, b0}) begin
                    n_err++;
                    $display("FAIL single_beat0 got %h required %h",
                             {bus4.acc_m_valid_o, bus4.acc_m_tfirst_o, bus4.acc_m_data_o}, {2'b11, b0});
                end
            end else if (i == 3) begin
                n_vec++;
                if ({bus4.acc_m_tlast_o, bus4.acc_m_data_o} !== {1'b1, b3}) begin
                    n_err++;
                    $display("FAIL single_beat3 got %h required %h",
                             {bus4.acc_m_tlast_o, bus4.acc_m_data_o}, {1'b1, b3});
                end
            end
            tick();
        end
        #1;
        n_vec++;
        if ({busy4, bus4.acc_m_valid_o} !== 2'b00) begin
            n_err++;
            $display("FAIL single_busy_drop got %b required 00", {busy4, bus4.acc_m_valid_o});
        end
    endtask

    task automatic test_back_to_back();
        tile_t t[3];
        int idx, stall;
        bit acc;
        for (int i = 0; i < 3; i++) t[i] = rand_tile();
        idx   = 0;
        stall = 0;
        for (int c = 0; c < 40 && (idx < 3 || pend_q.size() > 0); c++) begin
            drive4(idx < 3, (idx < 3) ? t[idx] : tile_t'(0), 1'b1, 1'b0);
            #1;
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL b2b cyc %0d: got %h required %h", cyc, got_vec(), exp_vec());
            end
            acc = (idx < 3) && (pend_q.size() < DEPTH);
            if (idx == 2 && !acc) stall++;
            tick();
            if (acc) idx++;
        end
        drive4(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_vec++;
        if (stall != 3 || idx != 3 || busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_third_stall got stall=%0d idx=%0d busy=%b required stall=3 idx=3 busy=0",
                     stall, idx, busy4);
        end
    endtask

    task automatic test_stall();
        int rp[8] = '{1, 1, 0, 0, 1, 1, 1, 1};
        logic [BEAT_W-1:0] held;
        held = '0;
        for (int c = 0; c < 8; c++) begin
            drive4(c == 0, rand_tile(), rp[c][0], 1'b0);
            #1;
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL stall cyc %0d: got %h required %h", cyc, got_vec(), exp_vec());
            end
            if (c == 2) held = bus4.acc_m_data_o;
            if (c == 3 || c == 4) begin
                n_vec++;
                if ({bus4.acc_m_valid_o, bus4.acc_m_tfirst_o, bus4.acc_m_data_o} !== {2'b10, held}) begin
                    n_err++;
                    $display("FAIL stall_hold c=%0d got %h required %h", c,
                             {bus4.acc_m_valid_o, bus4.acc_m_tfirst_o, bus4.acc_m_data_o}, {2'b10, held});
                end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 12; c++) begin
            drive4(c == 0 || c == 1 || c == 3 || c == 5, rand_tile(), 1'b1, c == 3);
            #1;
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL flush cyc %0d: got %h required %h", cyc, got_vec(), exp_vec());
            end
            if (c == 4) begin
                n_vec++;
                if ({bus4.acc_m_valid_o, pend4} !== 3'b000) begin
                    n_err++;
                    $display("FAIL flush_empty got %b required 000", {bus4.acc_m_valid_o, pend4});
                end
            end
            if (c == 6) begin
                n_vec++;
                if ({bus4.acc_m_valid_o, bus4.acc_m_tfirst_o} !== 2'b11) begin
                    n_err++;
                    $display("FAIL flush_restart got %b required 11", {bus4.acc_m_valid_o, bus4.acc_m_tfirst_o});
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            drive4(c == 0, rand_tile(), 1'b1, 1'b0);
            #1;
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rstmid cyc %0d: got %h required %h", cyc, got_vec(), exp_vec());
            end
            if (c < 2) tick();
        end
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if (got_vec() !== {VEC_W{1'b0}}) begin
            n_err++;
            $display("FAIL rstmid_outputs got %h required 0", got_vec());
        end
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            drive4(c == 1, rand_tile(), 1'b1, 1'b0);
            #1;
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rstmid_after cyc %0d: got %h required %h", cyc, got_vec(), exp_vec());
            end
            if (c == 2) begin
                n_vec++;
                if ({bus4.acc_m_valid_o, bus4.acc_m_tfirst_o} !== 2'b11) begin
                    n_err++;
                    $display("FAIL rstmid_first got %b required 11", {bus4.acc_m_valid_o, bus4.acc_m_tfirst_o});
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive4(1'($urandom_range(0, 1)), rand_tile(), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 31) == 0);
            #1;
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %h required %h", cyc, got_vec(), exp_vec());
            end
            tick();
        end
        drive4(1'b0, '0, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) tick();
    endtask

    task automatic test_odd_size();
        logic [ELEMS3*AW-1:0] t3;
        logic [BEAT_W-1:0]    d;
        for (int e = 0; e < ELEMS3; e++) t3[e*AW +: AW] = 32'h100 + 32'(e);
        bus3.tile_s_valid_i = 1'b1;
        bus3.tile_s_data_i  = t3;
        bus3.acc_m_ready_i  = 1'b1;
        #1;
        tick();
        bus3.tile_s_valid_i = 1'b0;
        for (int b = 0; b < BEATS3; b++) begin
            d = '0;
            for (int l = 0; l < LN; l++) begin
                if (b*LN + l < ELEMS3) d[l*AW +: AW] = 32'h100 + 32'(b*LN + l);
            end
            #1;
            n_vec++;
            if ({bus3.acc_m_valid_o, bus3.acc_m_tfirst_o, bus3.acc_m_tlast_o, bus3.acc_m_data_o}
                !== {1'b1, b == 0, b == BEATS3-1, d}) begin
                n_err++;
                $display("FAIL odd_beat%0d got %h required %h", b,
                         {bus3.acc_m_valid_o, bus3.acc_m_tfirst_o, bus3.acc_m_tlast_o, bus3.acc_m_data_o},
                         {1'b1, b == 0, b == BEATS3-1, d});
            end
            tick();
        end
        #1;
        n_vec++;
        if ({bus3.acc_m_valid_o, busy3} !== 2'b00) begin
            n_err++;
            $display("FAIL odd_done got %b required 00", {bus3.acc_m_valid_o, busy3});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        test_odd_size();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
